// File: rtl/vex_l15_bus_arbiter.sv
// vex_l15_bus_arbiter: merges VexRiscv iBus/dBus commands onto one request channel, one outstanding request.
// Optional response watchdog enabled by defining VEX_ARB_TIMEOUT_EN.
module vex_l15_bus_arbiter #(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ibus_cmd_valid,
  input  logic [31:0] ibus_cmd_pc,
  output logic        ibus_cmd_ready,
  output logic        ibus_rsp_valid,
  output logic [31:0] ibus_rsp_inst,
  output logic        ibus_rsp_error,
  input  logic        dbus_cmd_valid,
  input  logic        dbus_cmd_wr,
  input  logic [31:0] dbus_cmd_address,
  input  logic [31:0] dbus_cmd_data,
  input  logic [1:0]  dbus_cmd_size,
  output logic        dbus_cmd_ready,
  output logic        dbus_rsp_ready,
  output logic [31:0] dbus_rsp_data,
  output logic        dbus_rsp_error,
  output logic        arb_req_val,
  output logic        arb_req_is_data,
  output logic        arb_req_wr,
  output logic [31:0] arb_req_addr,
  output logic [31:0] arb_req_data,
  output logic [1:0]  arb_req_size,
  input  logic        arb_req_ack,
  input  logic        arb_rsp_val,
  input  logic [31:0] arb_rsp_data
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("vex_l15_bus_arbiter: parameter out of range");
  end
  state_t      r_state, w_next;
  logic [3:0]  r_d_streak;
  logic        r_req_is_data, r_req_wr;
  logic [31:0] r_req_addr, r_req_data;
  logic [1:0]  r_req_size;
  logic        r_ibus_cmd_ready, r_dbus_cmd_ready, r_ibus_rsp_valid, r_dbus_rsp_ready;
  logic [31:0] r_ibus_rsp_inst, r_dbus_rsp_data;
  logic        r_ibus_rsp_error, r_dbus_rsp_error;
  logic        w_i_req, w_d_req, w_grant, w_grant_i, w_ack, w_deliver, w_timeout, w_fin;
  // A command whose ready pulse is showing this cycle is the one already served.
  assign w_i_req   = ibus_cmd_valid && !r_ibus_cmd_ready;
  assign w_d_req   = dbus_cmd_valid && !r_dbus_cmd_ready;
  assign w_grant_i = w_i_req && (!w_d_req || r_d_streak == 4'(MAX_D_STREAK));
  assign w_grant   = (r_state == IDLE) && (w_i_req || w_d_req);
  assign w_ack     = (r_state == REQ) && arb_req_ack;
  assign w_deliver = arb_rsp_val && (w_ack || r_state == RSP);
  assign w_fin     = w_deliver || w_timeout;
`ifdef VEX_ARB_TIMEOUT_EN
  logic [15:0] r_wd;
  assign w_timeout = (r_state == RSP) && !arb_rsp_val && r_wd == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || r_state != RSP) r_wd <= '0;
    else r_wd <= r_wd + 16'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_grant ? REQ : IDLE;
      REQ:     w_next = arb_req_ack ? (arb_rsp_val ? IDLE : RSP) : REQ;
      RSP:     w_next = w_fin ? IDLE : RSP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_d_streak       <= '0;
      r_req_is_data    <= 1'b0;
      r_req_wr         <= 1'b0;
      r_req_addr       <= '0;
      r_req_data       <= '0;
      r_req_size       <= '0;
      r_ibus_cmd_ready <= 1'b0;
      r_dbus_cmd_ready <= 1'b0;
      r_ibus_rsp_valid <= 1'b0;
      r_dbus_rsp_ready <= 1'b0;
      r_ibus_rsp_inst  <= '0;
      r_dbus_rsp_data  <= '0;
      r_ibus_rsp_error <= 1'b0;
      r_dbus_rsp_error <= 1'b0;
    end else begin
      r_state          <= w_next;
      r_ibus_cmd_ready <= w_ack && !r_req_is_data;
      r_dbus_cmd_ready <= w_ack && r_req_is_data;
      r_ibus_rsp_valid <= w_fin && !r_req_is_data;
      r_dbus_rsp_ready <= w_fin && r_req_is_data;
      if (w_fin && !r_req_is_data) begin
        r_ibus_rsp_inst  <= w_timeout ? 32'd0 : arb_rsp_data;
        r_ibus_rsp_error <= w_timeout;
      end
      if (w_fin && r_req_is_data) begin
        r_dbus_rsp_data  <= (w_timeout || r_req_wr) ? 32'd0 : arb_rsp_data;
        r_dbus_rsp_error <= w_timeout;
      end
      if (w_grant) begin
        r_req_is_data <= !w_grant_i;
        r_req_wr      <= w_grant_i ? 1'b0 : dbus_cmd_wr;
        r_req_addr    <= w_grant_i ? ibus_cmd_pc : dbus_cmd_address;
        r_req_data    <= w_grant_i ? 32'd0 : dbus_cmd_data;
        r_req_size    <= w_grant_i ? 2'd2 : dbus_cmd_size;
        r_d_streak    <= (w_grant_i || !w_i_req) ? 4'd0 :
                         (r_d_streak == 4'(MAX_D_STREAK)) ? r_d_streak : r_d_streak + 4'd1;
      end
    end
  end
  assign arb_req_val     = (r_state == REQ);
  assign arb_req_is_data = r_req_is_data;
  assign arb_req_wr      = r_req_wr;
  assign arb_req_addr    = r_req_addr;
  assign arb_req_data    = r_req_data;
  assign arb_req_size    = r_req_size;
  assign ibus_cmd_ready  = r_ibus_cmd_ready;
  assign dbus_cmd_ready  = r_dbus_cmd_ready;
  assign ibus_rsp_valid  = r_ibus_rsp_valid;
  assign ibus_rsp_inst   = r_ibus_rsp_inst;
  assign ibus_rsp_error  = r_ibus_rsp_error;
  assign dbus_rsp_ready  = r_dbus_rsp_ready;
  assign dbus_rsp_data   = r_dbus_rsp_data;
  assign dbus_rsp_error  = r_dbus_rsp_error;
endmodule
